// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled 8-bit, even-parity, one-stop-bit frame decoder
// with its own baud tick generator selected by a 3-bit rate code.
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);

  // Clocks per oversample tick at a 50 MHz system clock.
  function automatic logic [13:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'b000:  baud_div = 14'd10417;
      3'b001:  baud_div = 14'd2604;
      3'b010:  baud_div = 14'd651;
      3'b011:  baud_div = 14'd326;
      3'b100:  baud_div = 14'd163;
      3'b101:  baud_div = 14'd81;
      3'b110:  baud_div = 14'd54;
      default: baud_div = 14'd27;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  logic [2:0]  baud_q;
  logic [13:0] div_cnt;
  logic [13:0] div_last;
  logic        baud_change;
  logic        tick;

  logic [2:0]  state;
  logic [3:0]  sample_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        parity_err;
  logic        prev_s;

  // NOTE: every clocked register below uses non-blocking assignment so all of
  // them update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // A rate change restarts the divider; no tick is issued on the reload cycle.
  assign baud_change = (baud_select != baud_q);
  assign div_last    = baud_div(baud_q) - 14'd1;
  assign tick        = !baud_change && (div_cnt == div_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q  <= 3'b000;
      div_cnt <= '0;
    end else begin
      baud_q <= baud_select;
      if (baud_change || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 14'd1;
      end
    end
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset along with the rest of the datapath to keep simulation X-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_err <= 1'b0;
      prev_s     <= 1'b0;
      Rx_DATA    <= 8'h00;
      Rx_VALID   <= 1'b0;
      Rx_PERROR  <= 1'b0;
      Rx_FERROR  <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      // prev_s tracks the line at every tick so a held-low break is not a new edge.
      if (tick) begin
        prev_s <= rxd_s;
      end

      if (!Rx_EN) begin
        state      <= S_IDLE;
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s && prev_s) begin
              state      <= S_START;
              sample_cnt <= '0;
              Rx_PERROR  <= 1'b0;
              Rx_FERROR  <= 1'b0;
            end
          end
          S_START: begin
            if (sample_cnt == MID_SAMPLE) begin
              sample_cnt <= '0;
              bit_cnt    <= '0;
              state      <= rxd_s ? S_IDLE : S_DATA;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          S_DATA: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == LAST_SAMPLE) begin
              shift[bit_cnt[2:0]] <= rxd_s;
              bit_cnt             <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= S_PARITY;
              end
            end
          end
          S_PARITY: begin
            sample_cnt <= sample_cnt + 4'd1;
            if (sample_cnt == LAST_SAMPLE) begin
              parity_err <= rxd_s ^ (^shift);
              state      <= S_STOP;
            end
          end
          S_STOP: begin
            sample_cnt <= sample_cnt + 4'd1;
            // Decision at mid-stop-bit leaves half a bit to catch a following start.
            if (sample_cnt == LAST_SAMPLE) begin
              if (rxd_s && !parity_err) begin
                Rx_DATA  <= shift;
                Rx_VALID <= 1'b1;
              end
              if (!rxd_s) begin
                Rx_FERROR <= 1'b1;
              end
              if (parity_err) begin
                Rx_PERROR <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive stage, the downstream counterpart of the team's UART transmitter; consumes the serial line that transmitter drives.
- Frame format matches the transmitter: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Oversamples RxD at 16x the baud rate using its own internal baud tick generator, selected by the same 3-bit baud_select encoding.
- Delivers the received byte with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RxD synchronizer (minimum 2).
- OVERSAMPLE, 16, ticks per bit; fixed at 16, not to be overridden.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- baud_select  input  3  baud rate code.
- Rx_EN  input  1  receiver enable.
- RxD  input  1  serial input, asynchronous to clk, idle high.
- Rx_DATA  output  8  last correctly received byte.
- Rx_VALID  output  1  one-clk pulse when Rx_DATA is updated.
- Rx_PERROR  output  1  parity error flag for the last frame.
- Rx_FERROR  output  1  framing error flag for the last frame.

Behaviour:
- Baud tick generator: a free-running counter produces a one-clk tick every DIV clocks. DIV values by baud_select:
  - 000 = 10417 (300 baud)
  - 001 = 2604 (1200)
  - 010 = 651 (4800)
  - 011 = 326 (9600)
  - 100 = 163 (19200)
  - 101 = 81 (38400)
  - 110 = 54 (57600)
  - 111 = 27 (115200)
- A change in baud_select reloads the counter; the frame in progress is corrupt and is not flagged.
- RxD passes through SYNC_STAGES flip-flops; all logic uses the synchronized value rxd_s. The register feeding rxd_s resets to 1.
- Reset (reset=0): state=IDLE, all counters 0, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0. Reset takes effect immediately at any point in a frame, with no output pulse.
- State machine: IDLE, START, DATA, PARITY, STOP. State transitions occur only on ticks, except the Rx_EN abort.
- IDLE: at each tick, if Rx_EN=1, rxd_s=0 and the previous tick sample was 1:
  - go to START with sample_cnt=0;
  - clear Rx_PERROR and Rx_FERROR.
  - A line held low (break) is never re-detected as a start until it has returned high.
- START: count 8 ticks to reach mid-bit, then re-sample rxd_s.
  - rxd_s=1: false start; return to IDLE, no flags set.
  - rxd_s=0: go to DATA with bit_cnt=0, sample_cnt=0.
- DATA: every 16th tick, sample rxd_s into shift[bit_cnt] (LSB first) and increment bit_cnt. After the 8th sample, go to PARITY.
- PARITY: at the 16th tick, sample the parity bit p. Parity error = p XOR (^shift); parity is even.
- STOP: at the 16th tick, sample the stop bit, then in that same clk:
  - stop=1 and no parity error: Rx_DATA<=shift, Rx_VALID=1 for exactly one clk.
  - stop=0: Rx_FERROR<=1.
  - parity error: Rx_PERROR<=1.
  - Both error flags can be set together. On any error, Rx_DATA holds its old value and Rx_VALID stays 0.
  - Go to IDLE. Sampling ends at mid-stop-bit, so a start bit that immediately follows is caught (back-to-back frames).
- Error flags stay high until the next valid start detection or reset.
- Rx_EN=0 in any state: return to IDLE on the next clk, discard the partial frame, leave outputs unchanged. Start detection is suppressed while Rx_EN=0.
- Counter widths: sample_cnt 4 bits, wraps 15->0; bit_cnt 4 bits; tick divider 14 bits.
- Latency: Rx_VALID asserts about 10.5 bit times after the start-bit falling edge, plus the synchronizer delay (SYNC_STAGES clk) and up to one tick of start-detect jitter.

Test Plan:
- Reset: assert reset=0 mid-frame -> all outputs 0, no Rx_VALID; after release, the next frame decodes normally.
- Basic frame at baud_select=011: drive 0xA5 with parity bit 0, stop 1 -> single Rx_VALID pulse, Rx_DATA=8'hA5, both flags 0, pulse at about 1.094 ms after the start edge.
- Parity error: send 0x3C with parity bit 1 -> Rx_VALID never asserts, Rx_PERROR=1, Rx_DATA unchanged; the next good frame clears the flag.
- Framing error and break: send 0x01 with stop bit 0, then hold RxD low for 3 frames -> Rx_FERROR=1 once, no further starts detected until RxD returns high.
- False start and back-to-back: a 4-tick low glitch -> no activity; then 0x00 followed immediately by 0xFF at baud_select=111 -> two Rx_VALID pulses, values 0x00 then 0xFF.
- Loopback and enable: connect the team's transmitter TxD to RxD and sweep all 8 baud_select codes with 0x55 and 0x80 -> every byte matches; dropping Rx_EN mid-frame -> no Rx_VALID for that frame.
